// File: rtl/farm_sensor_request.sv
// Farm-road loop conditioner: sync + debounce the loop, dwell-qualify presence, raise C until farm green.
// Latency: loop_raw edge to loop_db edge is 2+DEBOUNCE_CYC cycles; C and waiting are registered from next state.
// Backpressure: none; free-running stream of lamp and loop samples. FARM_LOOP_STUCK_EN adds the stuck-loop detector.
module farm_sensor_request #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TICK_DIV     = 4,
    parameter int ARM_TICKS    = 2,
    parameter int STUCK_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_raw,
    input  logic [2:0] light_highway,
    input  logic [2:0] light_farm,
    output logic       C,
    output logic       waiting,
    output logic [7:0] serve_count,
    output logic       loop_fault
);

    // Tick prescaler never narrower than 28 bits so a 50 MHz divider fits.
    localparam int TICK_W  = ($clog2(TICK_DIV) > 28) ? $clog2(TICK_DIV) : 28;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    // One width for both tick-count thresholds (dwell and stuck).
    localparam int DWELL_W = $clog2(((ARM_TICKS > STUCK_TICKS) ? ARM_TICKS : STUCK_TICKS) + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_REQUEST = 2'd2,
        S_SERVED  = 2'd3
    } state_t;

    logic               sync1_q, sync2_q;
    logic [DB_W-1:0]    db_cnt_q;
    logic [DB_W-1:0]    db_inc;
    logic               loop_db_q, loop_db_prev_q;
    logic               db_rise;
    logic [TICK_W-1:0]  tick_q;
    logic               tick;
    state_t             state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_inc;
    logic               c_q, c_d;
    logic               waiting_q, waiting_d;
    logic [7:0]         serve_count_q, serve_count_d;
    logic               fault_block;

    assign db_inc    = db_cnt_q + 1'b1;
    assign db_rise   = loop_db_q & ~loop_db_prev_q;
    assign tick      = (tick_q == TICK_W'(TICK_DIV - 1));
    assign dwell_inc = dwell_q + 1'b1;

    // Two-flop synchronizer for the asynchronous loop detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= loop_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYC cycles before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q       <= '0;
            loop_db_q      <= 1'b0;
            loop_db_prev_q <= 1'b0;
        end else begin
            loop_db_prev_q <= loop_db_q;
            if (sync2_q == loop_db_q) begin
                db_cnt_q <= '0;
            end else if (db_inc == DB_W'(DEBOUNCE_CYC)) begin
                loop_db_q <= sync2_q;
                db_cnt_q  <= '0;
            end else begin
                db_cnt_q <= db_inc;
            end
        end
    end

    // Free-running 1 s tick prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

`ifdef FARM_LOOP_STUCK_EN
    logic [DWELL_W-1:0] stuck_q, stuck_d;
    logic               loop_fault_q;

    // Stuck counter: ticks of uninterrupted presence, saturating at the threshold.
    always_comb begin
        stuck_d = stuck_q;
        if (!loop_db_q) begin
            stuck_d = '0;
        end else if (tick && (stuck_q != DWELL_W'(STUCK_TICKS))) begin
            stuck_d = stuck_q + 1'b1;
        end
    end

    // Stuck register and sticky fault flag; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_q      <= '0;
            loop_fault_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            if (stuck_d == DWELL_W'(STUCK_TICKS)) begin
                loop_fault_q <= 1'b1;
            end
        end
    end

    assign fault_block = loop_fault_q;
    assign loop_fault  = loop_fault_q;
`else
    assign fault_block = 1'b0;
    assign loop_fault  = 1'b0;
`endif

    // Next-state logic; registered outputs are decoded from the next state.
    always_comb begin
        state_d       = state_q;
        dwell_d       = dwell_q;
        case (state_q)
            S_IDLE: begin
                if (db_rise && !fault_block) begin
                    state_d = S_ARMED;
                    dwell_d = '0;
                end
            end
            S_ARMED: begin
                // Loss of presence takes priority over a completing dwell tick.
                if (!loop_db_q || fault_block) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    dwell_d = dwell_inc;
                    if (dwell_inc == DWELL_W'(ARM_TICKS)) begin
                        state_d = S_REQUEST;
                    end
                end
            end
            S_REQUEST: begin
                if (light_farm == 3'b001) begin
                    state_d = S_SERVED;
                end
            end
            S_SERVED: begin
                if ((light_farm == 3'b100) && (light_highway == 3'b001)) begin
                    if (loop_db_q && !fault_block) begin
                        state_d = S_ARMED;
                        dwell_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        c_d       = (state_d == S_REQUEST);
        waiting_d = (state_d == S_ARMED) || (state_d == S_REQUEST);

        serve_count_d = serve_count_q;
        if ((state_d == S_SERVED) && (state_q != S_SERVED) && (serve_count_q != 8'hFF)) begin
            serve_count_d = serve_count_q + 8'd1;
        end
    end

    // State, dwell and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dwell_q       <= '0;
            c_q           <= 1'b0;
            waiting_q     <= 1'b0;
            serve_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            c_q           <= c_d;
            waiting_q     <= waiting_d;
            serve_count_q <= serve_count_d;
        end
    end

    assign C           = c_q;
    assign waiting     = waiting_q;
    assign serve_count = serve_count_q;

endmodule

// File: tb/tb_farm_sensor_request.sv
// Bench for farm_sensor_request: timed expectations queued per scenario, compared as the cycle arrives.
// Latency: n counts posedges since reset release; ticks are consumed at posedges that are multiples of 4.
// Backpressure: none; inputs driven and outputs sampled on the falling edge.
module tb_farm_sensor_request;

    logic       clk;
    logic       rst;
    logic       loop_raw;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic       C;
    logic       waiting;
    logic [7:0] serve_count;
    logic       loop_fault;

    farm_sensor_request #(
        .DEBOUNCE_CYC(4),
        .TICK_DIV    (4),
        .ARM_TICKS   (2),
        .STUCK_TICKS (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .loop_raw     (loop_raw),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .C            (C),
        .waiting      (waiting),
        .serve_count  (serve_count),
        .loop_fault   (loop_fault)
    );

`ifdef FARM_LOOP_STUCK_EN
    localparam logic STUCK_EN = 1'b1;
`else
    localparam logic STUCK_EN = 1'b0;
`endif

    localparam int SIG_C   = 0;
    localparam int SIG_W   = 1;
    localparam int SIG_CNT = 2;
    localparam int SIG_F   = 3;

    typedef struct {
        int         at;
        int         sig;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic expect_at(input int at, input int sig, input logic [7:0] val);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] probe(input int sig);
        case (sig)
            SIG_C:   return {7'd0, C};
            SIG_W:   return {7'd0, waiting};
            SIG_CNT: return serve_count;
            default: return {7'd0, loop_fault};
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_C:   return "C";
            SIG_W:   return "waiting";
            SIG_CNT: return "serve_count";
            default: return "loop_fault";
        endcase
    endfunction

    function automatic int ceil4(input int x);
        return ((x + 3) / 4) * 4;
    endfunction

    task automatic test_reset();
        exp_t e;
        logic [7:0] got;
        rst = 1'b1;
        loop_raw = 1'b0;
        light_highway = 3'b001;
        light_farm = 3'b100;
        step();
        step();
        expect_at(n, SIG_C, 8'd0);
        expect_at(n, SIG_W, 8'd0);
        expect_at(n, SIG_CNT, 8'd0);
        expect_at(n, SIG_F, 8'd0);
        while (sb.size() > 0 && sb[0].at <= n) begin
            e = sb.pop_front();
            got = probe(e.sig);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL reset %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
            end
        end
        rst = 1'b0;
        n = 0;
        expect_at(8, SIG_C, 8'd0);
        expect_at(8, SIG_W, 8'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL reset_idle %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_glitch_filter();
        exp_t e;
        logic [7:0] got;
        int n0;
        // 3-cycle pulse is shorter than the debounce window: nothing happens.
        n0 = n;
        loop_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            expect_at(n0 + k, SIG_C, 8'd0);
            expect_at(n0 + k, SIG_W, 8'd0);
        end
        for (int c = 0; c < 14; c++) begin
            step();
            if (n == n0 + 3) loop_raw = 1'b0;
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL glitch3 %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
        // 4-cycle pulse just passes: brief ARMED, then back to IDLE.
        n0 = n;
        loop_raw = 1'b1;
        expect_at(n0 + 6, SIG_W, 8'd0);
        expect_at(n0 + 7, SIG_W, 8'd1);
        expect_at(n0 + 8, SIG_C, 8'd0);
        expect_at(n0 + 10, SIG_W, 8'd1);
        expect_at(n0 + 11, SIG_W, 8'd0);
        expect_at(n0 + 11, SIG_C, 8'd0);
        for (int c = 0; c < 14; c++) begin
            step();
            if (n == n0 + 4) loop_raw = 1'b0;
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL glitch4 %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_request();
        exp_t e;
        logic [7:0] got;
        int n0, t2;
        n0 = n;
        loop_raw = 1'b1;
        t2 = ceil4(n0 + 8) + 4;
        expect_at(n0 + 6, SIG_W, 8'd0);
        expect_at(n0 + 7, SIG_W, 8'd1);
        expect_at(n0 + 7, SIG_C, 8'd0);
        expect_at(t2 - 1, SIG_C, 8'd0);
        expect_at(t2, SIG_C, 8'd1);
        expect_at(t2, SIG_W, 8'd1);
        for (int c = 0; c < t2 + 1 - n0; c++) begin
            step();
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL request %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_serve_rearm();
        exp_t e;
        logic [7:0] got;
        int k, j, t2;
        k = n;
        light_highway = 3'b100;
        light_farm = 3'b001;
        j = k + 3;
        t2 = ceil4(j + 2) + 4;
        expect_at(k + 1, SIG_C, 8'd0);
        expect_at(k + 1, SIG_W, 8'd0);
        expect_at(k + 1, SIG_CNT, 8'd1);
        expect_at(k + 3, SIG_C, 8'd0);
        expect_at(k + 3, SIG_CNT, 8'd1);
        expect_at(j + 1, SIG_W, 8'd1);
        expect_at(j + 1, SIG_CNT, 8'd1);
        expect_at(t2 - 1, SIG_C, 8'd0);
        expect_at(t2, SIG_C, 8'd1);
        expect_at(t2, SIG_W, 8'd1);
        for (int c = 0; c < t2 - k; c++) begin
            step();
            if (n == k + 2) light_farm = 3'b010;
            if (n == j) begin
                light_highway = 3'b001;
                light_farm = 3'b100;
            end
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL serve_rearm %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_in_request();
        exp_t e;
        logic [7:0] got;
        rst = 1'b1;
        loop_raw = 1'b0;
        expect_at(n + 1, SIG_C, 8'd0);
        expect_at(n + 1, SIG_W, 8'd0);
        expect_at(n + 1, SIG_CNT, 8'd0);
        expect_at(n + 1, SIG_F, 8'd0);
        step();
        while (sb.size() > 0 && sb[0].at <= n) begin
            e = sb.pop_front();
            got = probe(e.sig);
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL reset_in_request %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
            end
        end
        rst = 1'b0;
        n = 0;
        expect_at(10, SIG_C, 8'd0);
        expect_at(10, SIG_W, 8'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL post_reset %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_loss_wins();
        exp_t e;
        logic [7:0] got;
        int n0, t2;
        n0 = n;
        loop_raw = 1'b1;
        t2 = ceil4(n0 + 8) + 4;
        expect_at(n0 + 7, SIG_W, 8'd1);
        for (int t = t2 - 4; t <= t2 + 6; t++) begin
            expect_at(t, SIG_C, 8'd0);
            if (t == t2 - 1) expect_at(t, SIG_W, 8'd1);
            if (t == t2) expect_at(t, SIG_W, 8'd0);
        end
        for (int c = 0; c < t2 + 6 - n0; c++) begin
            step();
            // loop_db then falls exactly in the cycle carrying the final dwell tick
            if (n == t2 - 7) loop_raw = 1'b0;
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL loss_wins %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    task automatic test_stuck_loop();
        exp_t e;
        logic [7:0] got;
        int n0, t2, f;
        n0 = n;
        loop_raw = 1'b1;
        t2 = ceil4(n0 + 8) + 4;
        f = ceil4(n0 + 7) + 76;
        expect_at(t2, SIG_C, 8'd1);
        expect_at(f - 1, SIG_C, 8'd1);
        expect_at(f - 1, SIG_F, 8'd0);
        expect_at(f, SIG_F, {7'd0, STUCK_EN});
        expect_at(f, SIG_C, 8'd1);
        expect_at(f + 3, SIG_C, 8'd0);
        expect_at(f + 3, SIG_CNT, 8'd1);
        expect_at(f + 6, SIG_W, {7'd0, !STUCK_EN});
        expect_at(f + 6, SIG_C, 8'd0);
        expect_at(f + 7, SIG_C, 8'd0);
        expect_at(f + 20, SIG_F, {7'd0, STUCK_EN});
        expect_at(f + 20, SIG_W, {7'd0, !STUCK_EN});
        expect_at(f + 20, SIG_C, {7'd0, !STUCK_EN});
        for (int c = 0; c < f + 20 - n0; c++) begin
            step();
            if (n == f + 2) begin
                light_highway = 3'b100;
                light_farm = 3'b001;
            end
            if (n == f + 5) begin
                light_highway = 3'b001;
                light_farm = 3'b100;
            end
            while (sb.size() > 0 && sb[0].at <= n) begin
                e = sb.pop_front();
                got = probe(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL stuck_loop %s cyc %0d: got %0h want %0h", sig_name(e.sig), n, got, e.val);
                end
            end
        end
    endtask

    initial begin
        n = 0;
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_glitch_filter();
        test_request();
        test_serve_rearm();
        test_reset_in_request();
        test_loss_wins();
        test_stuck_loop();
        if (sb.size() != 0) begin
            $display("FAIL leftover: got %0d unchecked expectations want 0", sb.size());
            n_checks += sb.size();
            n_fail += sb.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/farm_sensor_request.md
# farm_sensor_request

Vehicle-detection front end for the highway/farm traffic-light controller: conditions the raw farm-road loop detector and drives the controller's sensor request `C`. It synchronizes and debounces the loop, requires a vehicle to dwell before requesting, and holds `C` until the controller shows farm green. It then withdraws the request and re-arms only after the controller returns to highway green and farm red.

## Interface
- `DEBOUNCE_CYC`, default 4: consecutive cycles a synchronized loop level must differ from the debounced level before the debounced level changes.
- `TICK_DIV`, default 4: `clk` cycles per 1 s tick. Use 4 for the bench and 50_000_000 for a 50 MHz FPGA.
- `ARM_TICKS`, default 2: ticks the vehicle must dwell before `C` is raised.
- `STUCK_TICKS`, default 20: ticks of continuous presence that flag a stuck loop. Used only with the macro.
- `clk`  in  1  system clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `loop_raw`  in  1  asynchronous loop detector, 1 = metal present
- `light_highway`  in  3  controller highway lamp: 100 red, 010 yellow, 001 green
- `light_farm`  in  3  controller farm lamp, same encoding
- `C`  out  1  request to controller, registered
- `waiting`  out  1  FSM in ARMED or REQUEST
- `serve_count`  out  8  completed services, saturating at 255
- `loop_fault`  out  1  sticky stuck-loop flag, held 0 without the macro

## Operation
- Synchronizer: 2 flops on `loop_raw`, both reset to 0.
- Debounce: counter increments while the synchronized value differs from `loop_db`. It clears when they are equal. When it reaches `DEBOUNCE_CYC`, `loop_db` takes the synchronized value and the counter clears. `loop_db` resets to 0.
- Tick: free-running counter, 28-bit minimum, cycling 0..`TICK_DIV`-1. `tick` is 1 while the counter equals `TICK_DIV`-1. The counter resets to 0.
- FSM states, 2-bit encoding, reset to IDLE:
  - IDLE, `C`=0: on a rising `loop_db`, go to ARMED and clear `dwell`.
  - ARMED, `C`=0: `dwell` increments on each `tick`. If `loop_db`=0, return to IDLE. When a tick brings `dwell` to `ARM_TICKS`, go to REQUEST.
  - REQUEST, `C`=1: go to SERVED when `light_farm`==001. `loop_db` is ignored, so the request cannot be withdrawn once raised.
  - SERVED, `C`=0: `serve_count` increments on entry, saturating. Wait for `light_farm`==100 and `light_highway`==001. Then go to ARMED with `dwell` cleared if `loop_db`=1, else go to IDLE.
- `waiting` and `C` are registered and decoded from the next state, so they change in the same cycle as the state register.
- Lamp codes other than the one-hot values are treated as "not green / not red". The FSM holds its state.

## Timing
- Reset values: `C`=0, `waiting`=0, `serve_count`=0, `loop_fault`=0, FSM=IDLE, all counters 0.
- `loop_raw` edge to `loop_db` edge: 2 + `DEBOUNCE_CYC` cycles. Glitches shorter than `DEBOUNCE_CYC` cycles are filtered.
- `loop_db` rise to ARMED: 1 cycle.
- `C` rises in the cycle after the `ARM_TICKS`-th tick counted in ARMED.
- `C` falls 1 cycle after `light_farm` first samples 001.
- Simultaneous events in ARMED: `loop_db`=0 and the final tick in the same cycle go to IDLE, so loss of presence wins.
- `rst` asserted in any state returns all outputs to reset values on the next edge.

## Configuration
- `FARM_LOOP_STUCK_EN` defined:
  - A stuck counter counts ticks while `loop_db`=1 and clears when `loop_db`=0.
  - Reaching `STUCK_TICKS` sets `loop_fault`. Only `rst` clears it.
  - While `loop_fault`=1: IDLE→ARMED is suppressed and ARMED is forced to IDLE. REQUEST and SERVED complete normally, and SERVED exits to IDLE.
- Not defined: no stuck counter, `loop_fault` is constant 0, and FSM behaviour is as listed above.

## Test plan
- 3-cycle `loop_raw` pulse after reset → `loop_db` stays 0, `C` stays 0, FSM stays IDLE.
- `loop_raw`=1 held, lamps at highway 001 / farm 100 → `loop_db` rises 6 cycles after the input. `C` rises the cycle after the 2nd tick in ARMED. `waiting`=1 from ARMED entry.
- With `C`=1, drive farm 001 → `C`=0 next cycle and `serve_count` 0→1. Return to highway 001 / farm 100 with the loop still high → ARMED, and `C` is raised again after 2 ticks.
- Loop released in ARMED in the same cycle as the 2nd tick → IDLE, and `C` is never asserted.
- Assert `rst` while in REQUEST → next cycle `C`=0, `waiting`=0, `serve_count`=0, FSM IDLE.
- With `FARM_LOOP_STUCK_EN`, loop held 20+ ticks with the controller never granting → `loop_fault`=1 after 20 ticks. The REQUEST completes once farm 001 is driven, after which the FSM settles in IDLE with `C`=0 despite the loop staying high.
